// File: rtl/rv_debug_pkg.sv
// Shared definitions for the register-dump debug path: ASCII constants,
// hex digit encoding, serializer state encoding and frame geometry.
package rv_debug_pkg;

   localparam logic [7:0] X_CHR  = 8'h78;
   localparam logic [7:0] EQ_CHR = 8'h3D;
   localparam logic [7:0] CR_CHR = 8'h0D;
   localparam logic [7:0] LF_CHR = 8'h0A;

   localparam int unsigned FRAME_BYTES = 13;
   localparam int unsigned NUM_REGS    = 7;

   typedef enum logic [1:0] {
      IDLE,
      START_BIT,
      DATA,
      STOP_BIT
   } uart_state_t;

   // Uppercase hex: 0-9 -> '0'..'9', A-F -> 'A'..'F'
   function automatic logic [7:0] hex2ascii(input logic [3:0] nib);
      if (nib < 4'd10) return 8'h30 + {4'h0, nib};
      else             return 8'h37 + {4'h0, nib};
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer; ready rises in the last cycle of the stop bit so a byte
// presented then follows with no idle gap.
module uart_tx_byte
   import rv_debug_pkg::*;
#(
   parameter int unsigned DIV = 434
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] data,
   input  logic       valid,
   output logic       ready,
   output logic       tx
);

   localparam int unsigned     BW        = $clog2(DIV);
   localparam logic [BW-1:0]   BAUD_LAST = BW'(DIV - 1);

   uart_state_t   r_state;
   logic [BW-1:0] r_baud;
   logic [2:0]    r_bit;
   logic [7:0]    r_shift;
   logic          r_tx;
   logic          w_bit_end;

   assign w_bit_end = (r_baud == BAUD_LAST);
   assign ready     = (r_state == IDLE) || ((r_state == STOP_BIT) && w_bit_end);
   assign tx        = r_tx;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_baud  <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_tx    <= 1'b1;
      end else begin
         if (r_state != IDLE) r_baud <= w_bit_end ? '0 : r_baud + BW'(1);
         case (r_state)
            IDLE: begin
               if (valid) begin
                  r_shift <= data;
                  r_tx    <= 1'b0;
                  r_state <= START_BIT;
               end
            end
            START_BIT: begin
               if (w_bit_end) begin
                  r_tx    <= r_shift[0];
                  r_bit   <= '0;
                  r_state <= DATA;
               end
            end
            DATA: begin
               if (w_bit_end) begin
                  if (r_bit == 3'd7) begin
                     r_tx    <= 1'b1;
                     r_state <= STOP_BIT;
                  end else begin
                     r_tx    <= r_shift[1];
                     r_shift <= {1'b0, r_shift[7:1]};
                     r_bit   <= r_bit + 3'd1;
                  end
               end
            end
            STOP_BIT: begin
               if (w_bit_end) begin
                  if (valid) begin
                     r_shift <= data;
                     r_tx    <= 1'b0;
                     r_state <= START_BIT;
                  end else begin
                     r_state <= IDLE;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/reg_dump_uart.sv
// Snapshots debug taps x1..x7 on request and streams them as
// "xK=HHHHHHHH\r\n" lines over a UART 8N1 line.
module reg_dump_uart
   import rv_debug_pkg::*;
#(
   parameter int unsigned CLK_HZ = 50_000_000,
   parameter int unsigned BAUD   = 115200
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] debug_x1,
   input  logic [31:0] debug_x2,
   input  logic [31:0] debug_x3,
   input  logic [31:0] debug_x4,
   input  logic [31:0] debug_x5,
   input  logic [31:0] debug_x6,
   input  logic [31:0] debug_x7,
   output logic        tx,
   output logic        busy,
   output logic        done
);

   localparam int unsigned DIV = CLK_HZ / BAUD;

   if (DIV < 2) begin : g_bad_div
      $error("reg_dump_uart: CLK_HZ/BAUD must be at least 2");
   end

   localparam logic [3:0] CHR_LAST = 4'(FRAME_BYTES - 1);
   localparam logic [2:0] REG_LAST = 3'(NUM_REGS - 1);

   logic [31:0] r_snap [NUM_REGS];
   logic [2:0]  r_reg;
   logic [3:0]  r_chr;
   logic        r_busy;
   logic        r_done;

   logic        w_ready;
   logic        w_tx;
   logic        w_accept;
   logic        w_last;
   logic        w_adv;
   logic        w_valid;
   logic [3:0]  w_chr_nx;
   logic [2:0]  w_reg_nx;
   logic [31:0] w_word;
   logic [7:0]  w_char;
   logic [7:0]  w_data;

   assign w_accept = start && !r_busy;
   assign w_last   = (r_reg == REG_LAST) && (r_chr == CHR_LAST);
   assign w_adv    = r_busy && w_ready && !w_last;
   assign w_valid  = w_accept || w_adv;
   assign w_chr_nx = (r_chr == CHR_LAST) ? '0 : r_chr + 4'd1;
   assign w_reg_nx = (r_chr == CHR_LAST) ? r_reg + 3'd1 : r_reg;

   // Counters track the byte on the wire; the serializer is fed the byte after it.
   always_comb begin
      w_word = r_snap[w_reg_nx];
      w_char = X_CHR;
      case (w_chr_nx)
         4'd0:    w_char = X_CHR;
         4'd1:    w_char = 8'h31 + {5'b0, w_reg_nx};
         4'd2:    w_char = EQ_CHR;
         4'd3:    w_char = hex2ascii(w_word[31:28]);
         4'd4:    w_char = hex2ascii(w_word[27:24]);
         4'd5:    w_char = hex2ascii(w_word[23:20]);
         4'd6:    w_char = hex2ascii(w_word[19:16]);
         4'd7:    w_char = hex2ascii(w_word[15:12]);
         4'd8:    w_char = hex2ascii(w_word[11:8]);
         4'd9:    w_char = hex2ascii(w_word[7:4]);
         4'd10:   w_char = hex2ascii(w_word[3:0]);
         4'd11:   w_char = CR_CHR;
         4'd12:   w_char = LF_CHR;
         default: w_char = X_CHR;
      endcase
      w_data = w_accept ? X_CHR : w_char;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy <= 1'b0;
         r_done <= 1'b0;
         r_reg  <= '0;
         r_chr  <= '0;
         for (int unsigned i = 0; i < NUM_REGS; i++) r_snap[i] <= '0;
      end else begin
         r_done <= 1'b0;
         if (w_accept) begin
            r_busy    <= 1'b1;
            r_reg     <= '0;
            r_chr     <= '0;
            r_snap[0] <= debug_x1;
            r_snap[1] <= debug_x2;
            r_snap[2] <= debug_x3;
            r_snap[3] <= debug_x4;
            r_snap[4] <= debug_x5;
            r_snap[5] <= debug_x6;
            r_snap[6] <= debug_x7;
         end else if (r_busy && w_ready) begin
            if (w_last) begin
               r_busy <= 1'b0;
               r_done <= 1'b1;
               r_reg  <= '0;
               r_chr  <= '0;
            end else begin
               r_reg <= w_reg_nx;
               r_chr <= w_chr_nx;
            end
         end
      end
   end

   uart_tx_byte #(
      .DIV(DIV)
   ) u_tx (
      .clk  (clk),
      .rst  (rst),
      .data (w_data),
      .valid(w_valid),
      .ready(w_ready),
      .tx   (w_tx)
   );

   assign tx   = w_tx;
   assign busy = r_busy;
   assign done = r_done;

endmodule

// File: tb/tb_reg_dump_uart.sv
// Directed bench for reg_dump_uart at DIV=8; a UART receiver decodes tx at bit centres.
module tb_reg_dump_uart;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] x [7];
   logic        tx;
   logic        busy;
   logic        done;

   always #5 clk = ~clk;

   reg_dump_uart #(
      .CLK_HZ(8),
      .BAUD  (1)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .debug_x1(x[0]),
      .debug_x2(x[1]),
      .debug_x3(x[2]),
      .debug_x4(x[3]),
      .debug_x5(x[4]),
      .debug_x6(x[5]),
      .debug_x7(x[6]),
      .tx      (tx),
      .busy    (busy),
      .done    (done)
   );

   int unsigned vectors = 0;
   int unsigned errors  = 0;

   // Receiver: start bit seen at a falling negedge; samples 3.5 cycles into each bit.
   logic [7:0]  rx_q [$];
   logic        m_act = 1'b0;
   int unsigned m_cnt = 0;
   logic [7:0]  m_sh = '0;
   int unsigned frame_err = 0;
   int unsigned done_total = 0;

   always @(negedge clk) begin
      if (done === 1'b1) done_total++;
      if (rst === 1'b1) begin
         m_act = 1'b0;
      end else if (!m_act) begin
         if (tx === 1'b0) begin
            m_act = 1'b1;
            m_cnt = 0;
         end
      end else begin
         m_cnt++;
         if (m_cnt == 3) begin
            if (tx !== 1'b0) frame_err++;
         end else if (m_cnt > 3 && m_cnt < 75 && ((m_cnt - 3) % 8) == 0) begin
            m_sh = {tx, m_sh[7:1]};
         end else if (m_cnt == 75) begin
            if (tx !== 1'b1) frame_err++;
            rx_q.push_back(m_sh);
            m_act = 1'b0;
         end
      end
   end

   logic [103:0] exp_l [7];

   task automatic chk(input string tag, input logic [103:0] obs, input logic [103:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int unsigned n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_lines(input int unsigned base, input string tag);
      logic [103:0] obs;
      for (int unsigned k = 0; k < 7; k++) begin
         obs = '0;
         if (rx_q.size() >= base + 13 * (k + 1))
            for (int unsigned j = 0; j < 13; j++) obs = {obs[95:0], rx_q[base + 13 * k + j]};
         chk($sformatf("%s_line%0d", tag, k + 1), obs, exp_l[k]);
      end
   endtask

   // Called at the first negedge after the accept edge; returns at the negedge where busy fell.
   task automatic run_dump(input string tag, input int unsigned lock1, input int unsigned lock2);
      int unsigned cycles = 0;
      while (busy === 1'b1 && cycles < 8000) begin
         cycles++;
         start = (cycles == lock1 || cycles == lock2);
         tick(1);
      end
      start = 1'b0;
      chk({tag, "_busy_len"}, 104'(cycles), 104'(7280));
      chk({tag, "_done"}, 104'(done), 104'(1));
   endtask

   task automatic kick(input string tag);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      chk({tag, "_lat_tx"}, 104'(tx), 104'(0));
      chk({tag, "_lat_busy"}, 104'(busy), 104'(1));
   endtask

   int unsigned base;
   int unsigned d0;
   int unsigned quiet;

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      for (int i = 0; i < 7; i++) x[i] = '0;
      tick(3);
      chk("rst_tx", 104'(tx), 104'(1));
      chk("rst_busy", 104'(busy), 104'(0));
      chk("rst_done", 104'(done), 104'(0));
      rst   = 1'b0;
      quiet = 0;
      for (int i = 0; i < 100; i++) begin
         tick(1);
         if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) quiet++;
      end
      chk("idle_quiet", 104'(quiet), 104'(0));
      chk("idle_rx", 104'(rx_q.size()), 104'(0));

      // Basic dump
      x[0] = 32'hDEADBEEF;
      x[6] = 32'h0123A9F0;
      base = rx_q.size();
      d0   = done_total;
      kick("a");
      run_dump("a", 0, 0);
      tick(1);
      chk("a_done_1cyc", 104'(done), 104'(0));
      chk("a_tx_idle", 104'(tx), 104'(1));
      chk("a_bytes", 104'(rx_q.size() - base), 104'(91));
      chk("a_done_cnt", 104'(done_total - d0), 104'(1));
      exp_l[0] = "x1=DEADBEEF\r\n";
      exp_l[1] = "x2=00000000\r\n";
      exp_l[2] = "x3=00000000\r\n";
      exp_l[3] = "x4=00000000\r\n";
      exp_l[4] = "x5=00000000\r\n";
      exp_l[5] = "x6=00000000\r\n";
      exp_l[6] = "x7=0123A9F0\r\n";
      check_lines(base, "a");

      // Snapshot isolation plus busy lockout
      x[0] = 32'h12345678; x[1] = 32'h9ABCDEF0; x[2] = 32'h0F1E2D3C; x[3] = 32'h4B5A6978;
      x[4] = 32'h8796A5B4; x[5] = 32'hC3D2E1F0; x[6] = 32'hFEDCBA98;
      base = rx_q.size();
      d0   = done_total;
      kick("b");
      for (int i = 0; i < 7; i++) x[i] = 32'hFFFFFFFF;
      run_dump("b", 100, 3000);
      tick(200);
      chk("b_no_requeue", 104'(busy), 104'(0));
      chk("b_bytes", 104'(rx_q.size() - base), 104'(91));
      chk("b_done_cnt", 104'(done_total - d0), 104'(1));
      exp_l[0] = "x1=12345678\r\n";
      exp_l[1] = "x2=9ABCDEF0\r\n";
      exp_l[2] = "x3=0F1E2D3C\r\n";
      exp_l[3] = "x4=4B5A6978\r\n";
      exp_l[4] = "x5=8796A5B4\r\n";
      exp_l[5] = "x6=C3D2E1F0\r\n";
      exp_l[6] = "x7=FEDCBA98\r\n";
      check_lines(base, "b");

      // Back-to-back: start held in the done cycle
      for (int i = 0; i < 7; i++) x[i] = 32'h11111111 * (i + 1);
      base = rx_q.size();
      d0   = done_total;
      kick("c");
      run_dump("c", 0, 0);
      kick("d");
      run_dump("d", 0, 0);
      tick(1);
      chk("cd_bytes", 104'(rx_q.size() - base), 104'(182));
      chk("cd_done_cnt", 104'(done_total - d0), 104'(2));
      exp_l[0] = "x1=11111111\r\n";
      exp_l[1] = "x2=22222222\r\n";
      exp_l[2] = "x3=33333333\r\n";
      exp_l[3] = "x4=44444444\r\n";
      exp_l[4] = "x5=55555555\r\n";
      exp_l[5] = "x6=66666666\r\n";
      exp_l[6] = "x7=77777777\r\n";
      check_lines(base, "c");
      check_lines(base + 91, "d");

      // Reset during data bit 3 of the 20th byte
      base = rx_q.size();
      d0   = done_total;
      kick("r");
      tick(1554);
      rst = 1'b1;
      tick(1);
      chk("r_tx", 104'(tx), 104'(1));
      chk("r_busy", 104'(busy), 104'(0));
      chk("r_done", 104'(done), 104'(0));
      rst = 1'b0;
      tick(50);
      chk("r_bytes", 104'(rx_q.size() - base), 104'(19));
      chk("r_no_done", 104'(done_total - d0), 104'(0));
      chk("r_idle_tx", 104'(tx), 104'(1));

      // Clean dump after the aborted one
      x[0] = 32'h89ABCDEF; x[1] = 32'h00000001; x[2] = 32'h10000000; x[3] = 32'h0000FFFF;
      x[4] = 32'hFFFF0000; x[5] = 32'h5A5A5A5A; x[6] = 32'hA5A5A5A5;
      base = rx_q.size();
      d0   = done_total;
      kick("e");
      run_dump("e", 0, 0);
      tick(1);
      chk("e_bytes", 104'(rx_q.size() - base), 104'(91));
      chk("e_done_cnt", 104'(done_total - d0), 104'(1));
      exp_l[0] = "x1=89ABCDEF\r\n";
      exp_l[1] = "x2=00000001\r\n";
      exp_l[2] = "x3=10000000\r\n";
      exp_l[3] = "x4=0000FFFF\r\n";
      exp_l[4] = "x5=FFFF0000\r\n";
      exp_l[5] = "x6=5A5A5A5A\r\n";
      exp_l[6] = "x7=A5A5A5A5\r\n";
      check_lines(base, "e");
      chk("frame_errors", 104'(frame_err), 104'(0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
